// File: rtl/two_com_serial_dec.sv
// two_com_serial_dec
//   Collects one WIDTH-bit two's-complement word, LSB first, and reports
//   it as sign and magnitude. The word is negated on the fly using the
//   serial rule: bits are copied up to and including the first 1, and
//   every later bit is inverted.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     begin collecting a word (accepted only in IDLE)
//   bit_in    serial data, LSB first
//   bit_valid bit_in is valid this cycle (consumed only in SHIFT)
//   sign      sign of the last decoded word (1 = negative)
//   mag       magnitude of the last decoded word
//   min_neg   last word was the most-negative value (1 followed by zeros)
//   busy      high while bits are being collected
//   done      one-cycle pulse when sign/mag/min_neg update
module two_com_serial_dec #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             sign,
  output logic [WIDTH-1:0] mag,
  output logic             min_neg,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] copy_r;
  logic [WIDTH-1:0] neg_r;
  logic             seen_r;

  logic [WIDTH-1:0] copy_nxt_s;
  logic [WIDTH-1:0] neg_nxt_s;
  logic [WIDTH-1:0] mag_nxt_s;
  logic             min_nxt_s;

  // Shift-register contents including the bit currently on bit_in.
  always_comb begin
    copy_nxt_s        = copy_r;
    neg_nxt_s         = neg_r;
    copy_nxt_s[cnt_r] = bit_in;
    if (seen_r) begin
      neg_nxt_s[cnt_r] = ~bit_in;
    end else begin
      neg_nxt_s[cnt_r] = bit_in;
    end
    // On the final bit, bit_in is the sign bit.
    if (bit_in) begin
      mag_nxt_s = neg_nxt_s;
    end else begin
      mag_nxt_s = copy_nxt_s;
    end
    min_nxt_s = (copy_nxt_s == MOST_NEG);
  end

  // Control FSM, bit collection and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      copy_r  <= {WIDTH{1'b0}};
      neg_r   <= {WIDTH{1'b0}};
      seen_r  <= 1'b0;
      sign    <= 1'b0;
      mag     <= {WIDTH{1'b0}};
      min_neg <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r <= SHIFT;
            busy    <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
            copy_r  <= {WIDTH{1'b0}};
            neg_r   <= {WIDTH{1'b0}};
            seen_r  <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          if (bit_valid) begin
            copy_r <= copy_nxt_s;
            neg_r  <= neg_nxt_s;
            seen_r <= seen_r | bit_in;
            if (cnt_r == LAST_CNT) begin
              state_r <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              sign    <= bit_in;
              mag     <= mag_nxt_s;
              min_neg <= min_nxt_s;
            end else begin
              cnt_r <= cnt_r + 1'b1;
            end
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_two_com_serial_dec.sv
// Testbench for two_com_serial_dec (WIDTH=4). Directed words with
// hand-computed results are pushed to a scoreboard queue; a monitor pops
// and compares whenever done is seen.
module tb_two_com_serial_dec;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       bit_in;
  logic       bit_valid;
  logic       sign;
  logic [3:0] mag;
  logic       min_neg;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic       sign;
    logic [3:0] mag;
    logic       min_neg;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  logic prev_done = 1'b0;

  two_com_serial_dec #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in),
    .bit_valid(bit_valid), .sign(sign), .mag(mag), .min_neg(min_neg),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: compare every done pulse against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sign", int'(sign), int'(e.sign));
        check("mag", int'(mag), int'(e.mag));
        check("min_neg", int'(min_neg), int'(e.min_neg));
        check("latency", cyc, e.cyc);
      end
      if (prev_done) check("done_width", 2, 1);
    end
    prev_done = done;
  end

  // Send one word LSB first; optional stall before bit stall_after and
  // optional start pokes during SHIFT and DONE.
  task automatic send_word(input logic [3:0] w, input logic e_sign,
                           input logic [3:0] e_mag, input logic e_min,
                           input int stall_after, input int stall_len,
                           input bit poke_start);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e.sign = e_sign; e.mag = e_mag; e.min_neg = e_min;
    e.cyc = cyc + 4 + stall_len;
    exp_q.push_back(e);
    check("busy_shift", int'(busy), 1);
    for (int k = 0; k < 4; k++) begin
      if (k == stall_after) begin
        for (int s = 0; s < stall_len; s++) begin
          bit_valid = 1'b0;
          bit_in    = ~w[k];
          start     = poke_start;
          @(negedge clk);
        end
        start = 1'b0;
      end
      bit_valid = 1'b1;
      bit_in    = w[k];
      start     = (poke_start && k == 1);
      @(negedge clk);
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    start     = poke_start;   // lands while in DONE
    @(negedge clk);
    start = 1'b0;
    check("busy_idle", int'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_sign", int'(sign), 0);
    check("rst_mag", int'(mag), 0);
    check("rst_min_neg", int'(min_neg), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);

    send_word(4'b0000, 1'b0, 4'b0000, 1'b0, 9, 0, 1'b0);
    send_word(4'b0001, 1'b0, 4'b0001, 1'b0, 9, 0, 1'b0);
    send_word(4'b0101, 1'b0, 4'b0101, 1'b0, 9, 0, 1'b0);
    send_word(4'b0111, 1'b0, 4'b0111, 1'b0, 9, 0, 1'b0);
    send_word(4'b1001, 1'b1, 4'b0111, 1'b0, 9, 0, 1'b0);
    send_word(4'b1110, 1'b1, 4'b0010, 1'b0, 9, 0, 1'b0);
    send_word(4'b1000, 1'b1, 4'b1000, 1'b1, 9, 0, 1'b0);
    send_word(4'b0011, 1'b0, 4'b0011, 1'b0, 9, 0, 1'b0);
    // Stall of 3 cycles after bit 2, with start poked during SHIFT/DONE.
    send_word(4'b1110, 1'b1, 4'b0010, 1'b0, 2, 3, 1'b1);
    // bit_valid pulsed in IDLE must not be consumed.
    @(negedge clk);
    bit_valid = 1'b1; bit_in = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0; bit_in = 1'b0;
    check("idle_bit_busy", int'(busy), 0);
    send_word(4'b1110, 1'b1, 4'b0010, 1'b0, 9, 0, 1'b0);

    // Reset after 2 bits of 1001: partial word discarded.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; bit_valid = 1'b1; bit_in = 1'b1;
    @(negedge clk);
    bit_in = 1'b0;
    @(negedge clk);
    bit_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_sign", int'(sign), 0);
    check("arst_mag", int'(mag), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_sign", int'(sign), 0);
    check("post_rst_mag", int'(mag), 0);
    check("post_rst_min_neg", int'(min_neg), 0);
    check("post_rst_busy", int'(busy), 0);
    send_word(4'b0101, 1'b0, 4'b0101, 1'b0, 9, 0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
